// File: rtl/clockworks.sv
// Board clock/reset conditioning: optional CLK/2**SLOW divider (enabled by CLOCKWORKS_DIV_EN)
// and a synchronized, stretched active-low core reset that is released on a clk rising edge.
module clockworks #(
  parameter int SLOW         = 0,
  parameter int RESET_CYCLES = 16
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic resetn
);

  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RESET_CYCLES);

`ifdef CLOCKWORKS_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  generate
    if (DIV_EN && (SLOW > 0)) begin : g_div
      // clk comes straight off the divider MSB flop, so it is glitch-free and 50% duty.
      logic [SLOW-1:0] div = '0;

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) div <= '0;
        else       div <= div + 1'b1;
      end

      assign clk = div[SLOW-1];
    end else begin : g_pass
      assign clk = CLK;
    end
  endgenerate

  logic          s1       = 1'b0;
  logic          s2       = 1'b0;
  logic [CW-1:0] cnt      = '0;
  logic          resetn_q = 1'b0;

  // Declaration values give the same power-up state as RESET, so the core
  // sees one full stretched reset even if the board never pulses RESET.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      cnt      <= '0;
      resetn_q <= 1'b0;
    end else begin
      s1       <= 1'b1;
      s2       <= s1;
      if (s2 && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
      resetn_q <= s2 && (cnt == CNT_MAX);
    end
  end

  assign resetn = resetn_q;

endmodule

// File: tb/tb_clockworks.sv
// Directed bench for clockworks: a pass-through instance (SLOW=0, 16-cycle stretch) and a
// SLOW=2, 4-cycle-stretch instance whose clock depends on whether CLOCKWORKS_DIV_EN is defined.
module tb_clockworks;

`ifdef CLOCKWORKS_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif

  logic CLK = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic clk_a, resetn_a, clk_b, resetn_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  clockworks #(.SLOW(0), .RESET_CYCLES(16)) u_a (
    .CLK(CLK), .RESET(rst_a), .clk(clk_a), .resetn(resetn_a)
  );

  clockworks #(.SLOW(2), .RESET_CYCLES(4)) u_b (
    .CLK(CLK), .RESET(rst_b), .clk(clk_b), .resetn(resetn_b)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
  endtask

  // Walks n CLK edges after a release (or power-up). Edge e is counted from the
  // release point: instance a releases on edge 19, instance b on its 7th clk edge,
  // which with the /4 divider is CLK edge 26 (b's k-th clk edge is CLK edge 4k-2).
  task automatic check_seq(input string tag, input int n);
    logic exp_cb, exp_rb;
    for (int e = 1; e <= n; e++) begin
      @(posedge CLK);
      #1;
      exp_cb = DIV ? ((e % 4) >= 2) : 1'b1;
      exp_rb = DIV ? (e >= 26) : (e >= 7);
      chk({tag, "_resetn_a"}, resetn_a, (e >= 19));
      chk({tag, "_resetn_b"}, resetn_b, exp_rb);
      chk({tag, "_clk_a_hi"}, clk_a, 1'b1);
      chk({tag, "_clk_b_pos"}, clk_b, exp_cb);
      @(negedge CLK);
      #1;
      chk({tag, "_clk_a_lo"}, clk_a, 1'b0);
      chk({tag, "_clk_b_neg"}, clk_b, DIV ? exp_cb : 1'b0);
    end
  endtask

  initial begin
    // Power-up with RESET tied low: registers start at their reset values.
    #1;
    chk("pwr_resetn_a", resetn_a, 1'b0);
    chk("pwr_resetn_b", resetn_b, 1'b0);
    chk("pwr_clk_b", clk_b, 1'b0);
    check_seq("pwr", 30);

    // RESET while resetn is high: immediate drop, clk_b held low when divided.
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    chk("assert_resetn_a", resetn_a, 1'b0);
    chk("assert_resetn_b", resetn_b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      chk("hold_resetn_a", resetn_a, 1'b0);
      chk("hold_resetn_b", resetn_b, 1'b0);
      chk("hold_clk_a", clk_a, 1'b1);
      chk("hold_clk_b", clk_b, DIV ? 1'b0 : 1'b1);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Release, then glitch mid-stretch (instance b at cnt=2) with a 1ns pulse.
    check_seq("rel", DIV ? 14 : 4);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("glitch_resetn_a", resetn_a, 1'b0);
    chk("glitch_resetn_b", resetn_b, 1'b0);
    chk("glitch_clk_b", clk_b, 1'b0);

    // Full sequence must restart from scratch, then resetn stays high.
    check_seq("restart", 30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
